rhs_frame_packetizer: RTL

// - Sits downstream of the RHS stim/acquisition controller and upstream of the clk_dma AXI-Stream DMA S2MM port.
// - Frames raw 32-channel sample streams into DMA packets:
//   - per frame: 64-bit magic number followed by NUM_CH channel words;
//   - per packet: batch_size frames, with TLAST on the final word.
// - Yields 136 B/frame, matching the packet-length register contract.

---
 rtl/rhs_frame_packetizer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/rhs_frame_packetizer.sv
// Frames 32-channel RHS sample words into DMA packets: magic header per frame, TLAST per batch.
// Optional per-frame timestamp word after the header is enabled by defining RHS_FRAME_TIMESTAMP_EN.
module rhs_frame_packetizer #(
    parameter int          NUM_CH  = 32,
    parameter logic [63:0] MAGIC   = 64'hD7A22AAA38132A53,
    parameter int          BATCH_W = 8
) (
    input  logic               clk_dma,
    input  logic               rst_dma,
    input  logic               enable,
    input  logic [BATCH_W-1:0] batch_size,
    input  logic [31:0]        s_axis_tdata,
    input  logic               s_axis_tvalid,
    input  logic               s_axis_tlast,
    output logic               s_axis_tready,
    output logic [31:0]        m_axis_tdata,
    output logic               m_axis_tvalid,
    output logic               m_axis_tlast,
    input  logic               m_axis_tready,
    output logic               busy,
    output logic [31:0]        pkt_count,
    output logic               frame_err
);

    localparam int                WCNT_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NUM_CH - 1);

`ifdef RHS_FRAME_TIMESTAMP_EN
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MAGIC_LO = 3'd1,
        ST_MAGIC_HI = 3'd2,
        ST_TS       = 3'd3,
        ST_DATA     = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MAGIC_LO = 3'd1,
        ST_MAGIC_HI = 3'd2,
        ST_DATA     = 3'd4
    } state_t;
`endif

    state_t             state_reg;
    logic [BATCH_W-1:0] bcnt_reg;
    logic [BATCH_W-1:0] fcnt_reg;
    logic [WCNT_W-1:0]  wcnt_reg;
    logic [31:0]        pkt_count_reg;
    logic               frame_err_reg;
    logic [31:0]        m_data_reg;
    logic               m_valid_reg;
    logic               m_last_reg;
`ifdef RHS_FRAME_TIMESTAMP_EN
    logic [31:0]        ts_cnt_reg;
`endif

    logic               load_ok;
    logic               s_accept;
    logic               frame_end;
    logic               word_mismatch;
    logic               pkt_done;
    logic [BATCH_W-1:0] bcnt_last;

    // The output register frees up either when empty or when the DMA takes its word this cycle.
    assign load_ok       = !m_valid_reg || m_axis_tready;
    assign s_axis_tready = (state_reg == ST_DATA) && load_ok;
    assign s_accept      = s_axis_tvalid && s_axis_tready;

    // A frame ends on upstream tlast or when the last channel slot is filled (resync).
    assign frame_end     = s_axis_tlast || (wcnt_reg == LAST_WORD);
    assign word_mismatch = s_axis_tlast != (wcnt_reg == LAST_WORD);
    assign bcnt_last     = bcnt_reg - BATCH_W'(1);
    assign pkt_done      = (fcnt_reg == bcnt_last) || !enable;

    assign m_axis_tdata  = m_data_reg;
    assign m_axis_tvalid = m_valid_reg;
    assign m_axis_tlast  = m_last_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign pkt_count     = pkt_count_reg;
    assign frame_err     = frame_err_reg;

    always_ff @(posedge clk_dma) begin
        if (rst_dma) begin
            state_reg     <= ST_IDLE;
            bcnt_reg      <= '0;
            fcnt_reg      <= '0;
            wcnt_reg      <= '0;
            pkt_count_reg <= '0;
            frame_err_reg <= 1'b0;
            m_data_reg    <= '0;
            m_valid_reg   <= 1'b0;
            m_last_reg    <= 1'b0;
`ifdef RHS_FRAME_TIMESTAMP_EN
            ts_cnt_reg    <= '0;
`endif
        end else begin
            if (m_valid_reg && m_axis_tready) begin
                m_valid_reg <= 1'b0;
                m_last_reg  <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (enable) begin
                        bcnt_reg  <= (batch_size == '0) ? BATCH_W'(1) : batch_size;
                        fcnt_reg  <= '0;
                        state_reg <= ST_MAGIC_LO;
                    end
                end

                ST_MAGIC_LO: begin
                    if (load_ok) begin
                        m_data_reg  <= MAGIC[31:0];
                        m_valid_reg <= 1'b1;
                        m_last_reg  <= 1'b0;
                        state_reg   <= ST_MAGIC_HI;
                    end
                end

                ST_MAGIC_HI: begin
                    if (load_ok) begin
                        m_data_reg  <= MAGIC[63:32];
                        m_valid_reg <= 1'b1;
                        m_last_reg  <= 1'b0;
                        wcnt_reg    <= '0;
`ifdef RHS_FRAME_TIMESTAMP_EN
                        state_reg   <= ST_TS;
`else
                        state_reg   <= ST_DATA;
`endif
                    end
                end

`ifdef RHS_FRAME_TIMESTAMP_EN
                ST_TS: begin
                    if (load_ok) begin
                        m_data_reg  <= ts_cnt_reg;
                        m_valid_reg <= 1'b1;
                        m_last_reg  <= 1'b0;
                        ts_cnt_reg  <= ts_cnt_reg + 32'd1;
                        state_reg   <= ST_DATA;
                    end
                end
`endif

                ST_DATA: begin
                    if (s_accept) begin
                        m_data_reg  <= s_axis_tdata;
                        m_valid_reg <= 1'b1;
                        if (frame_end) begin
                            if (word_mismatch) begin
                                frame_err_reg <= 1'b1;
                            end
                            m_last_reg <= pkt_done;
                            if (pkt_done) begin
                                pkt_count_reg <= pkt_count_reg + 32'd1;
                                state_reg     <= ST_IDLE;
                            end else begin
                                fcnt_reg  <= fcnt_reg + BATCH_W'(1);
                                state_reg <= ST_MAGIC_LO;
                            end
                        end else begin
                            m_last_reg <= 1'b0;
                            wcnt_reg   <= wcnt_reg + WCNT_W'(1);
                        end
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
